char_write_scheduler: RTL

- Shares the single character-screen write port between several character printers, e.g. the target tracker printer, score printer and PS/2 line printer.
- Each printer runs a start/finish handshake and drives a (char_index, char_data) pair every cycle.
- The block latches requests, grants one printer at a time in round-robin order, pulses that printer's start, and forwards its index/data stream to the screen RAM with a write enable.
- It also aborts any printer that hangs.

---
 rtl/char_sched_pkg.sv | 21 ++
 rtl/char_write_scheduler_rr_arbiter.sv | 31 +++
 rtl/char_write_scheduler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/char_sched_pkg.sv
// Shared types and helpers for the character-screen write scheduler.
package char_sched_pkg;

    localparam int unsigned DEF_IDX_W  = 8;
    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ACK,
        ST_BUSY,
        ST_ABORT,
        ST_GAP
    } sched_state_e;

    // Low bit of client k's field inside a packed per-client bus of field width w.
    function automatic int unsigned slice_lo(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/char_write_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first pending client searching upward from ptr+1 with wrap.
module rr_arbiter #(
    parameter int unsigned NUM_CLIENTS = 3,
    parameter int unsigned GID_W       = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] pending,
    input  logic [GID_W-1:0]       ptr,
    output logic                   found_c,
    output logic [GID_W-1:0]       winner_c
);

    logic [2*NUM_CLIENTS-1:0] doubled;
    logic [NUM_CLIENTS-1:0]   rotated;

    // rotated[j] is the pending bit of client (ptr+1+j) mod NUM_CLIENTS
    assign doubled = {pending, pending};
    assign rotated = NUM_CLIENTS'(doubled >> (32'(ptr) + 32'd1));

    // Lowest set rotated bit wins; map it back to a client id
    always_comb begin
        found_c  = 1'b0;
        winner_c = '0;
        for (int unsigned j = 0; j < NUM_CLIENTS; j++) begin
            if (!found_c && rotated[j]) begin
                found_c  = 1'b1;
                winner_c = GID_W'((32'(ptr) + 32'd1 + j) % NUM_CLIENTS);
            end
        end
    end

endmodule

// File: rtl/char_write_scheduler.sv
// Shares one character-screen write port between several printers, round-robin,
// with start/finish handshake and hang protection.
module char_write_scheduler
    import char_sched_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 3,
    parameter int unsigned IDX_W       = DEF_IDX_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ACK_LIMIT   = 4,
    parameter int unsigned RUN_LIMIT   = 64
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic [NUM_CLIENTS-1:0]        req,
    output logic [NUM_CLIENTS-1:0]        start,
    input  logic [NUM_CLIENTS-1:0]        finish,
    input  logic [NUM_CLIENTS*IDX_W-1:0]  cl_index,
    input  logic [NUM_CLIENTS*DATA_W-1:0] cl_data,
    output logic                          wr_en,
    output logic [IDX_W-1:0]              wr_index,
    output logic [DATA_W-1:0]             wr_data,
    output logic [$clog2(NUM_CLIENTS)-1:0] grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int unsigned GID_W   = $clog2(NUM_CLIENTS);
    localparam int unsigned LIM_MAX = (ACK_LIMIT > RUN_LIMIT) ? ACK_LIMIT : RUN_LIMIT;
    localparam int unsigned CNT_W   = $clog2(LIM_MAX) + 1;
    localparam logic [CNT_W-1:0] ACK_LIM = CNT_W'(ACK_LIMIT);
    localparam logic [CNT_W-1:0] RUN_LIM = CNT_W'(RUN_LIMIT);

    sched_state_e             state, state_n;
    logic [NUM_CLIENTS-1:0]   pending, pending_n, pend_clr;
    logic [GID_W-1:0]         ptr, ptr_n, gid_n;
    logic [CNT_W-1:0]         cnt, cnt_n, cnt_inc;
    logic [NUM_CLIENTS-1:0]   start_n;
    logic                     wr_en_n, timeout_n;
    logic [IDX_W-1:0]         wr_index_n;
    logic [DATA_W-1:0]        wr_data_n;
    logic                     found_c;
    logic [GID_W-1:0]         winner_c;
    logic                     fin_g;

    logic [IDX_W-1:0]  idx_arr [NUM_CLIENTS];
    logic [DATA_W-1:0] dat_arr [NUM_CLIENTS];

    // Split the packed client buses into per-client fields
    for (genvar k = 0; k < NUM_CLIENTS; k++) begin : g_split
        assign idx_arr[k] = cl_index[slice_lo(k, IDX_W) +: IDX_W];
        assign dat_arr[k] = cl_data[slice_lo(k, DATA_W) +: DATA_W];
    end

    rr_arbiter #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .GID_W       (GID_W)
    ) u_arb (
        .pending  (pending),
        .ptr      (ptr),
        .found_c  (found_c),
        .winner_c (winner_c)
    );

    assign fin_g   = finish[grant_id];
    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

    // Next-state and registered-output decode
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        gid_n      = grant_id;
        cnt_n      = cnt;
        pend_clr   = '0;
        start_n    = '0;
        wr_en_n    = 1'b0;
        wr_index_n = wr_index;
        wr_data_n  = wr_data;
        timeout_n  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (found_c) begin
                    state_n  = ST_START;
                    gid_n    = winner_c;
                    ptr_n    = winner_c;
                    pend_clr = NUM_CLIENTS'(1) << winner_c;
                    start_n  = NUM_CLIENTS'(1) << winner_c;
                end
            end
            ST_START: begin
                state_n = ST_ACK;
                cnt_n   = '0;
            end
            ST_ACK: begin
                if (!fin_g) begin
                    state_n = ST_BUSY;
                    cnt_n   = '0;
                end else if (cnt_inc >= ACK_LIM) begin
                    state_n   = ST_ABORT;
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_BUSY: begin
                // A hung printer gets RUN_LIMIT writes; the next cycle aborts and its data is dropped
                if (fin_g) begin
                    state_n    = ST_GAP;
                    wr_en_n    = 1'b1;
                    wr_index_n = idx_arr[grant_id];
                    wr_data_n  = dat_arr[grant_id];
                end else if (cnt >= RUN_LIM) begin
                    state_n   = ST_ABORT;
                    timeout_n = 1'b1;
                end else begin
                    wr_en_n    = 1'b1;
                    wr_index_n = idx_arr[grant_id];
                    wr_data_n  = dat_arr[grant_id];
                    cnt_n      = cnt_inc;
                end
            end
            ST_ABORT: state_n = ST_GAP;
            ST_GAP:   state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase

        // A request arriving on its own grant cycle stays pending
        pending_n = (pending & ~pend_clr) | req;
    end

    // State, bookkeeping and output registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            pending     <= '0;
            ptr         <= '0;
            cnt         <= '0;
            grant_id    <= '0;
            start       <= '0;
            wr_en       <= 1'b0;
            wr_index    <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            pending     <= pending_n;
            ptr         <= ptr_n;
            cnt         <= cnt_n;
            grant_id    <= gid_n;
            start       <= start_n;
            wr_en       <= wr_en_n;
            wr_index    <= wr_index_n;
            wr_data     <= wr_data_n;
            busy        <= (state_n != ST_IDLE);
            timeout_err <= timeout_n;
        end
    end

endmodule
